// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and sequencing controller for the five-stage RV64 core.
// It detects load-use hazards between decode and execute, applies PC
// redirects from execute, and holds the front of the pipe while the
// multi-cycle mul/div unit (MDU) is busy, with a timeout that aborts the
// wait. It also keeps saturating stall and flush performance counters.
//
// Ports:
//   clk, rst                     core clock, synchronous active-high reset
//   id_rs1/rs2_addr_i, _used_i   register reads of the decode instruction
//   ex_rd_addr_i, ex_reg_wen_i   destination of the execute instruction
//   ex_is_load_i                 execute instruction is a load
//   ex_jump_en_i, ex_jump_addr_i taken branch/jump resolved in execute
//   mdu_start_i, mdu_done_i      MDU handshake
//   jump_en_o, jump_addr_o       PC redirect (combinational)
//   hold_*_o, flush_*_o          pipeline register controls (combinational)
//   mdu_timeout_o                sticky MDU timeout flag (registered)
//   stall_cnt_o, flush_cnt_o     saturating performance counters (registered)
module pipe_ctrl #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MDU_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_reg_wen_i,
    input  logic             ex_is_load_i,
    input  logic             ex_jump_en_i,
    input  logic [63:0]      ex_jump_addr_i,
    input  logic             mdu_start_i,
    input  logic             mdu_done_i,
    output logic             jump_en_o,
    output logic [63:0]      jump_addr_o,
    output logic             hold_pc_o,
    output logic             hold_if_id_o,
    output logic             hold_id_ex_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             mdu_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned WCNT_W = $clog2(MDU_TIMEOUT + 1);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MDU_BUSY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              load_use;
    logic              wcnt_expired;

    // A load writing a non-zero rd that decode really reads must stall one cycle.
    assign load_use = ex_is_load_i & ex_reg_wen_i & (ex_rd_addr_i != 5'd0) &
                      ((id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                       (id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i)));

    assign wcnt_expired = (wcnt_q == WCNT_W'(MDU_TIMEOUT));

    // Next-state and control decode.
    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        timeout_d     = timeout_q;
        jump_en_o     = 1'b0;
        jump_addr_o   = 64'd0;
        hold_pc_o     = 1'b0;
        hold_if_id_o  = 1'b0;
        hold_id_ex_o  = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;

        if (rst) begin
            state_d   = ST_RUN;
            wcnt_d    = '0;
            timeout_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (ex_jump_en_i) begin
                        // Redirect wins; both wrong-path instructions are squashed.
                        jump_en_o     = 1'b1;
                        jump_addr_o   = ex_jump_addr_i;
                        flush_if_id_o = 1'b1;
                        flush_id_ex_o = 1'b1;
                    end else if (mdu_start_i) begin
                        hold_pc_o    = 1'b1;
                        hold_if_id_o = 1'b1;
                        hold_id_ex_o = 1'b1;
                        state_d      = ST_MDU_BUSY;
                        wcnt_d       = WCNT_W'(1);
                    end else if (load_use) begin
                        // Hold the consumer in decode, send a bubble into execute.
                        hold_pc_o     = 1'b1;
                        hold_if_id_o  = 1'b1;
                        flush_id_ex_o = 1'b1;
                    end
                end
                ST_MDU_BUSY: begin
                    if (mdu_done_i) begin
                        // Done cycle is not stalled so the result advances.
                        state_d = ST_RUN;
                        wcnt_d  = '0;
                    end else if (wcnt_expired) begin
                        timeout_d = 1'b1;
                        state_d   = ST_RUN;
                        wcnt_d    = '0;
                    end else begin
                        hold_pc_o    = 1'b1;
                        hold_if_id_o = 1'b1;
                        hold_id_ex_o = 1'b1;
                        wcnt_d       = wcnt_q + WCNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    wcnt_d  = '0;
                end
            endcase
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hold_pc_o && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (jump_en_o && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State, wait counter, sticky flag and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wcnt_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mdu_timeout_o = timeout_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with CNT_W=4 (so saturation is reachable)
// and MDU_TIMEOUT=8.
module tb_pipe_ctrl;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned TO    = 8;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs1_addr_i, id_rs2_addr_i;
    logic             id_rs1_used_i, id_rs2_used_i;
    logic [4:0]       ex_rd_addr_i;
    logic             ex_reg_wen_i, ex_is_load_i, ex_jump_en_i;
    logic [63:0]      ex_jump_addr_i;
    logic             mdu_start_i, mdu_done_i;
    logic             jump_en_o;
    logic [63:0]      jump_addr_o;
    logic             hold_pc_o, hold_if_id_o, hold_id_ex_o;
    logic             flush_if_id_o, flush_id_ex_o;
    logic             mdu_timeout_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    int passed = 0;
    int total  = 0;

    pipe_ctrl #(.CNT_W(CNT_W), .MDU_TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1_addr_i  (id_rs1_addr_i),
        .id_rs2_addr_i  (id_rs2_addr_i),
        .id_rs1_used_i  (id_rs1_used_i),
        .id_rs2_used_i  (id_rs2_used_i),
        .ex_rd_addr_i   (ex_rd_addr_i),
        .ex_reg_wen_i   (ex_reg_wen_i),
        .ex_is_load_i   (ex_is_load_i),
        .ex_jump_en_i   (ex_jump_en_i),
        .ex_jump_addr_i (ex_jump_addr_i),
        .mdu_start_i    (mdu_start_i),
        .mdu_done_i     (mdu_done_i),
        .jump_en_o      (jump_en_o),
        .jump_addr_o    (jump_addr_o),
        .hold_pc_o      (hold_pc_o),
        .hold_if_id_o   (hold_if_id_o),
        .hold_id_ex_o   (hold_id_ex_o),
        .flush_if_id_o  (flush_if_id_o),
        .flush_id_ex_o  (flush_id_ex_o),
        .mdu_timeout_o  (mdu_timeout_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Control bundle order: jump_en, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex
    task automatic check_ctrl(input string tag, input logic [5:0] exp);
        check(tag, {58'd0, jump_en_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
                    flush_if_id_o, flush_id_ex_o}, {58'd0, exp});
    endtask

    task automatic clear_inputs();
        id_rs1_addr_i  = 5'd0;
        id_rs2_addr_i  = 5'd0;
        id_rs1_used_i  = 1'b0;
        id_rs2_used_i  = 1'b0;
        ex_rd_addr_i   = 5'd0;
        ex_reg_wen_i   = 1'b0;
        ex_is_load_i   = 1'b0;
        ex_jump_en_i   = 1'b0;
        ex_jump_addr_i = 64'd0;
        mdu_start_i    = 1'b0;
        mdu_done_i     = 1'b0;
    endtask

    // Advance to just after the next rising edge; inputs are then driven and
    // checked before the following edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2);
        ex_is_load_i  = 1'b1;
        ex_reg_wen_i  = 1'b1;
        ex_rd_addr_i  = rd;
        id_rs1_addr_i = rs1;
        id_rs1_used_i = u1;
        id_rs2_addr_i = rs2;
        id_rs2_used_i = u2;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        next_cycle();

        // Reset forces every control to 0 even with active requests.
        ex_jump_en_i   = 1'b1;
        ex_jump_addr_i = 64'h1234;
        mdu_start_i    = 1'b1;
        #1;
        check_ctrl("rst_ctrl", 6'b000000);
        check("rst_jaddr", jump_addr_o, 64'd0);
        next_cycle();
        check("rst_stall", 64'(stall_cnt_o), 64'd0);
        check("rst_flush", 64'(flush_cnt_o), 64'd0);
        check("rst_tmo", 64'(mdu_timeout_o), 64'd0);
        clear_inputs();
        rst = 1'b0;
        #1;
        check_ctrl("idle", 6'b000000);
        next_cycle();

        // Load-use on rs2.
        set_load_use(5'd5, 5'd3, 1'b1, 5'd5, 1'b1);
        #1;
        check_ctrl("lu_stall", 6'b011001);
        next_cycle();
        clear_inputs();
        #1;
        check_ctrl("lu_after", 6'b000000);
        check("lu_stall_cnt", 64'(stall_cnt_o), 64'd1);
        next_cycle();

        // Load to x0 and unused-operand matches are not hazards.
        set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        #1;
        check_ctrl("x0_load", 6'b000000);
        next_cycle();
        set_load_use(5'd7, 5'd7, 1'b0, 5'd7, 1'b0);
        #1;
        check_ctrl("unused_ops", 6'b000000);
        next_cycle();

        // Jump wins over load_use and mdu_start.
        set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        mdu_start_i    = 1'b1;
        ex_jump_en_i   = 1'b1;
        ex_jump_addr_i = 64'h0000_0000_8000_0040;
        #1;
        check_ctrl("jmp_ctrl", 6'b100011);
        check("jmp_addr", jump_addr_o, 64'h0000_0000_8000_0040);
        next_cycle();
        clear_inputs();
        ex_jump_addr_i = 64'hdead_beef;
        #1;
        check("jmp_addr_zero", jump_addr_o, 64'd0);
        check("jmp_flush_cnt", 64'(flush_cnt_o), 64'd1);
        check("jmp_stall_cnt", 64'(stall_cnt_o), 64'd1);
        next_cycle();

        // MDU: start, 4 busy cycles, done on the 5th; a jump in busy is ignored.
        clear_inputs();
        mdu_start_i = 1'b1;
        #1;
        check_ctrl("mdu_start", 6'b011100);
        next_cycle();
        mdu_start_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            ex_jump_en_i   = (i == 2);
            ex_jump_addr_i = 64'h40;
            #1;
            check_ctrl($sformatf("mdu_busy%0d", i), 6'b011100);
            next_cycle();
        end
        clear_inputs();
        mdu_done_i = 1'b1;
        #1;
        check_ctrl("mdu_done", 6'b000000);
        next_cycle();
        clear_inputs();
        #1;
        check_ctrl("mdu_run", 6'b000000);
        check("mdu_stall_cnt", 64'(stall_cnt_o), 64'd6);
        check("mdu_flush_cnt", 64'(flush_cnt_o), 64'd1);
        next_cycle();

        // Reset in busy cycle 3, then a late done has no effect.
        mdu_start_i = 1'b1;
        next_cycle();
        mdu_start_i = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        #1;
        check_ctrl("rstb_ctrl", 6'b000000);
        next_cycle();
        rst = 1'b0;
        mdu_done_i = 1'b1;
        #1;
        check_ctrl("rstb_done", 6'b000000);
        check("rstb_stall", 64'(stall_cnt_o), 64'd0);
        check("rstb_flush", 64'(flush_cnt_o), 64'd0);
        next_cycle();
        clear_inputs();
        #1;
        check_ctrl("rstb_run", 6'b000000);
        next_cycle();
        set_load_use(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        #1;
        check_ctrl("rstb_lu", 6'b011001);
        next_cycle();
        clear_inputs();

        // Timeout: holds on start + 7 busy cycles, released on busy cycle 8.
        mdu_start_i = 1'b1;
        #1;
        check_ctrl("to_start", 6'b011100);
        next_cycle();
        mdu_start_i = 1'b0;
        for (int i = 1; i < int'(TO); i++) begin
            #1;
            check_ctrl($sformatf("to_busy%0d", i), 6'b011100);
            next_cycle();
        end
        #1;
        check_ctrl("to_release", 6'b000000);
        check("to_flag_pre", 64'(mdu_timeout_o), 64'd0);
        next_cycle();
        check("to_flag", 64'(mdu_timeout_o), 64'd1);
        check("to_stall_cnt", 64'(stall_cnt_o), 64'd9);
        check_ctrl("to_run", 6'b000000);
        next_cycle();
        next_cycle();
        check("to_sticky", 64'(mdu_timeout_o), 64'd1);

        // Second timeout pushes the stall counter past 15: saturates.
        mdu_start_i = 1'b1;
        next_cycle();
        mdu_start_i = 1'b0;
        for (int i = 0; i < int'(TO) + 1; i++) next_cycle();
        check("stall_sat", 64'(stall_cnt_o), 64'd15);

        // 16 jumps saturate the flush counter at 15.
        for (int i = 0; i < 16; i++) begin
            ex_jump_en_i   = 1'b1;
            ex_jump_addr_i = 64'(i * 4);
            next_cycle();
        end
        clear_inputs();
        #1;
        check("flush_sat", 64'(flush_cnt_o), 64'd15);
        check("sticky_still", 64'(mdu_timeout_o), 64'd1);

        // Reset clears the sticky flag and counters.
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        check("fin_tmo", 64'(mdu_timeout_o), 64'd0);
        check("fin_stall", 64'(stall_cnt_o), 64'd0);
        check("fin_flush", 64'(flush_cnt_o), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard and sequencing controller for the five-stage RV64 core. It watches the decode stage's register reads, the id_ex register's destination, branch/jump resolution from execute, and the multi-cycle mul/div unit handshake. From these it drives hold and flush controls to pc, if_id and id_ex, and the PC redirect. It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter
- MDU_TIMEOUT, 64, maximum MDU_BUSY cycles before forced abort

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_rs1_addr_i  in  5  rs1 index read by the instruction in decode
- id_rs2_addr_i  in  5  rs2 index read by the instruction in decode
- id_rs1_used_i  in  1  decode instruction really reads rs1
- id_rs2_used_i  in  1  decode instruction really reads rs2
- ex_rd_addr_i  in  5  destination of the instruction in execute
- ex_reg_wen_i  in  1  execute instruction writes rd
- ex_is_load_i  in  1  execute instruction is a load
- ex_jump_en_i  in  1  execute resolved a taken branch/jal/jalr
- ex_jump_addr_i  in  64  target of that jump
- mdu_start_i  in  1  execute holds a mul/div; MDU started this cycle
- mdu_done_i  in  1  MDU result valid this cycle
- jump_en_o  out  1  PC load strobe
- jump_addr_o  out  64  PC load value
- hold_pc_o  out  1  PC keeps its value
- hold_if_id_o  out  1  if_id keeps its contents
- hold_id_ex_o  out  1  id_ex keeps its contents
- flush_if_id_o  out  1  if_id loads a NOP (inst 0x00000013)
- flush_id_ex_o  out  1  id_ex loads a bubble (reg_wen 0, rd 0)
- mdu_timeout_o  out  1  sticky: an MDU operation timed out
- stall_cnt_o  out  CNT_W  cycles with hold_pc_o asserted
- flush_cnt_o  out  CNT_W  taken redirects

## Operation
- The controller has two states: RUN and MDU_BUSY. It also holds a wait counter wcnt of width clog2(MDU_TIMEOUT+1).
- load_use = ex_is_load_i & ex_reg_wen_i & (ex_rd_addr_i != 0) & ((id_rs1_used_i & id_rs1_addr_i == ex_rd_addr_i) | (id_rs2_used_i & id_rs2_addr_i == ex_rd_addr_i)).
- In RUN, the first matching case in this priority order applies:
  - ex_jump_en_i: jump_en_o=1, jump_addr_o=ex_jump_addr_i, flush_if_id_o=1, flush_id_ex_o=1. State stays RUN. Any mdu_start_i or load_use in the same cycle is ignored.
  - mdu_start_i: hold_pc_o, hold_if_id_o and hold_id_ex_o all =1. Next state is MDU_BUSY with wcnt=1.
  - load_use: hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1. This inserts one bubble, and state stays RUN.
  - Otherwise all controls are 0.
- In MDU_BUSY:
  - While mdu_done_i=0, all three holds are 1 and wcnt increments.
  - When mdu_done_i=1, all holds are 0 that same cycle so the result advances, and the next state is RUN.
  - When mdu_done_i=0 and wcnt==MDU_TIMEOUT, holds are 0, mdu_timeout_o is set (sticky until rst), and the next state is RUN.
  - ex_jump_en_i, mdu_start_i and load_use are ignored.
- Control outputs are combinational from state and inputs. jump_addr_o is 0 whenever jump_en_o=0.
- stall_cnt_o increments each cycle hold_pc_o=1. flush_cnt_o increments each cycle jump_en_o=1. Both saturate at all-ones.
- Reset: state RUN, wcnt 0, mdu_timeout_o 0, both counters 0. While rst=1, every control output is forced 0.

## Timing
- Redirect takes effect in the same cycle: the PC loads jump_addr_o at the next edge, and the two wrong-path instructions are flushed at that edge.
- A load-use stall costs exactly 1 cycle. On the following cycle execute holds the bubble, so load_use is 0.
- An MDU stall of N busy cycles (mdu_done_i arriving N cycles after mdu_start_i) costs N cycles with holds asserted. The done cycle itself is not stalled.
- A timeout releases the holds exactly MDU_TIMEOUT cycles after the start cycle.
- If rst is asserted mid-MDU_BUSY, the next state is RUN and holds drop at once. mdu_done_i arriving after reset is ignored.
- ex_rd_addr_i==0 never causes a stall. A load followed by a consumer of x0 is not a hazard.

## Test plan
- Load-use: load x5 in EX, decode reads x5 via rs2 (used=1) -> one cycle with hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1; following cycle all 0; stall_cnt_o=1.
- Jump: ex_jump_en_i=1, addr 0x80000040, with load_use also true -> jump_en_o=1, addr 0x80000040, both flushes=1, no holds; flush_cnt_o=1.
- MDU: mdu_start_i, then mdu_done_i 5 cycles later -> holds=1 for the start cycle plus 4 busy cycles, 0 on the done cycle; state RUN; stall_cnt_o=5.
- Timeout with MDU_TIMEOUT=8: mdu_start_i, no done -> holds released on the 8th busy cycle; mdu_timeout_o=1 and stays 1 until rst.
- Reset in MDU_BUSY: rst for 1 cycle at busy cycle 3 -> outputs 0, counters 0, state RUN; a later mdu_done_i produces no effect.
- x0 and unused operands: load to x0 with a matching decode read, or a match with used=0 -> no hold, no flush.
